plb_adc: RTL and testbench
==========================

PLB_ADC -- requirements
Module: plb_adc

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sys_clk_pin cycles per S_ADC_Clk period; even, >=2.
REQ-002 SHALL have parameter WARMUP_CYC, default 64: sys_clk_pin cycles from power-up to the first S_ADC_Clk edge.
REQ-003 SHALL have parameter PIPE_LAT, default 5: number of initial ADC samples discarded for ADC pipeline latency.
REQ-004 SHALL have FIFO depth fixed at 16 entries of 10 bits.
REQ-005 SHALL have ports (clock and reset first):
- sys_clk_pin  in  1  sole clock
- sys_rst_pin  in  1  reset, asynchronous, active-low
- S_Enable  in  1  level; 1 = acquire
- S_ADC_Data  in  [0:9]  ADC parallel output, bit 0 = MSB
- S_ADC_OTR  in  1  ADC out-of-range flag
- S_ADC_Clk  out  1  ADC conversion clock
- S_PWRDN  out  1  ADC power-down, 1 = powered down
- Rd_Req  in  1  pop request, one word per cycle
- Rd_Data  out  [0:9]  popped sample
- Rd_Valid  out  1  Rd_Data valid, one-cycle pulse
- Fifo_Count  out  5  entries held, 0..16
- Fifo_Empty  out  1  Fifo_Count==0
- Overflow  out  1  sticky; sample dropped on full FIFO
- Otr_Seen  out  1  sticky; an accepted sample had OTR=1
- Status_Clr  in  1  clears Overflow and Otr_Seen

Function
REQ-006 SHALL implement FSM OFF -> WARMUP -> SKIP -> RUN.
- OFF: S_PWRDN=1, S_ADC_Clk=0, divider held at 0; S_Enable=1 -> WARMUP.
- WARMUP: S_PWRDN=0; after WARMUP_CYC cycles -> SKIP.
- SKIP: S_ADC_Clk toggles; first PIPE_LAT captured samples are discarded; then -> RUN.
- RUN: every captured sample is pushed.
REQ-007 SHALL, from any state, enter OFF on the cycle after S_Enable is sampled 0.
REQ-008 SHALL drive S_ADC_Clk from div_cnt (0..CLK_DIV-1): 1 when div_cnt < CLK_DIV/2, else 0; registered output, glitch-free.
REQ-009 SHALL capture S_ADC_Data and S_ADC_OTR at the sys_clk_pin edge that ends the cycle with div_cnt==CLK_DIV-1, giving one sample per CLK_DIV cycles.
REQ-010 SHALL push a RUN-state sample into the FIFO the cycle after capture; sample-to-readable latency is 2 cycles.
REQ-011 SHALL, on Rd_Req=1 with FIFO non-empty, present the oldest word on Rd_Data with Rd_Valid=1 on the next cycle.
REQ-012 SHALL ignore Rd_Req while empty: Rd_Valid stays 0 and Rd_Data holds its value.
REQ-013 SHALL leave Fifo_Count unchanged on a simultaneous push and pop, including when full.
REQ-014 SHALL, on a push with the FIFO full and no pop, drop the new sample, keep the contents, and set Overflow.
REQ-015 SHALL set Otr_Seen when a sample with OTR=1 is pushed.
REQ-016 SHALL clear the sticky flags on Status_Clr; a set event in the same cycle wins (flag = 1).
REQ-017 SHALL retain FIFO contents in OFF; reads remain serviced.
REQ-018 SHALL wrap the read and write pointers modulo 16.

Reset
REQ-019 SHALL, when sys_rst_pin=0 (asynchronous), force: FSM=OFF, S_PWRDN=1, S_ADC_Clk=0, Rd_Data=0, Rd_Valid=0, Fifo_Count=0, Fifo_Empty=1, Overflow=0, Otr_Seen=0, all counters and pointers 0.
REQ-020 SHALL release reset synchronously to sys_clk_pin; a reset asserted mid-acquisition discards all FIFO contents.

Configuration
REQ-021 SHALL support macro PLB_ADC_AVG4_EN.
- Defined: four consecutive RUN samples are summed into 12 bits; bits [11:2] form one pushed word, one push per 4 samples, OTR ORed across the four.
- Undefined: every sample is pushed unmodified.
- SKIP-state discard is unaffected in both cases.

Verification
REQ-022 Reset, then S_Enable=1 with defaults -> S_PWRDN falls next cycle; first S_ADC_Clk rise at cycle 64; samples 1-5 discarded; sample 6 readable 2 cycles after its capture.
REQ-023 Ramp S_ADC_Data 0x000,0x001,...; read 16 words -> Rd_Data 0x005..0x014 in order; Fifo_Empty=1 afterwards.
REQ-024 No reads in RUN for 17 samples -> Fifo_Count=16, Overflow=1, contents = first 16 samples; Status_Clr -> Overflow=0.
REQ-025 S_ADC_OTR=1 on one sample -> Otr_Seen=1 after the push; Rd_Req on an empty FIFO -> Rd_Valid stays 0.
REQ-026 Drop S_Enable mid-RUN with 3 words held -> OFF next cycle, S_ADC_Clk=0, S_PWRDN=1, 3 words still readable; reassert -> WARMUP restarts.
REQ-027 PLB_ADC_AVG4_EN defined, inputs 0x3FF,0x3FF,0x001,0x001 -> one push of 0x200.

Source files
------------

// File: rtl/plb_adc.sv
// -----------------------------------------------------------------------------
// plb_adc -- free-running parallel ADC front end with a 16 x 10-bit sample FIFO.
//
// Brings the ADC out of power-down and waits WARMUP_CYC cycles. It then
// generates S_ADC_Clk (one period every CLK_DIV cycles) and drops the first
// PIPE_LAT samples, which are still in the converter pipeline. After that,
// every captured sample is pushed into the FIFO.
//
// Optional build macro: PLB_ADC_AVG4_EN
//   Defined   : four consecutive RUN samples are summed into 12 bits.
//               Bits [11:2] of the sum are pushed as one word, and OTR is
//               ORed across the four samples.
//   Undefined : every RUN sample is pushed unmodified.
//
// Ports
//   sys_clk_pin   in   sole clock
//   sys_rst_pin   in   asynchronous active-low reset
//   S_Enable      in   1 = acquire; 0 = power down (FIFO contents kept)
//   S_ADC_Data    in   [0:9] ADC sample, bit 0 = MSB
//   S_ADC_OTR     in   ADC out-of-range flag
//   S_ADC_Clk     out  registered ADC conversion clock
//   S_PWRDN       out  1 = ADC powered down
//   Rd_Req        in   pop one word (ignored while empty)
//   Rd_Data       out  [0:9] popped word, held between pops
//   Rd_Valid      out  one-cycle pulse, Rd_Data updated
//   Fifo_Count    out  words held, 0..16
//   Fifo_Empty    out  Fifo_Count == 0
//   Overflow      out  sticky, a sample was dropped on a full FIFO
//   Otr_Seen      out  sticky, a pushed sample carried OTR = 1
//   Status_Clr    in   clears Overflow / Otr_Seen (a same-cycle set wins)
// -----------------------------------------------------------------------------
module plb_adc #(
   parameter int CLK_DIV    = 4,
   parameter int WARMUP_CYC = 64,
   parameter int PIPE_LAT   = 5
) (
   input  logic        sys_clk_pin,
   input  logic        sys_rst_pin,
   input  logic        S_Enable,
   input  logic [0:9]  S_ADC_Data,
   input  logic        S_ADC_OTR,
   output logic        S_ADC_Clk,
   output logic        S_PWRDN,
   input  logic        Rd_Req,
   output logic [0:9]  Rd_Data,
   output logic        Rd_Valid,
   output logic [4:0]  Fifo_Count,
   output logic        Fifo_Empty,
   output logic        Overflow,
   output logic        Otr_Seen,
   input  logic        Status_Clr
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int WW = $clog2(WARMUP_CYC + 1);
   localparam int SW = $clog2(PIPE_LAT + 1) + 1;

   typedef enum logic [1:0] {OFF, WARMUP, SKIP, RUN} state_t;

   state_t          state, state_nxt;
   logic [WW-1:0]   warm_cnt;
   logic [DW-1:0]   div_cnt, div_nxt;
   logic [SW-1:0]   skip_cnt;
   logic            adc_clk_q;
   logic            acq, acq_nxt, cap_tick, run_tick;

   assign acq      = (state == SKIP) || (state == RUN);
   assign acq_nxt  = (state_nxt == SKIP) || (state_nxt == RUN);
   // Sample at the edge that closes the last divider slot; a cycle with
   // S_Enable low is already heading to OFF and takes no sample.
   assign cap_tick = acq && S_Enable && (div_cnt == DW'(CLK_DIV - 1));
   assign run_tick = cap_tick && (state == RUN);

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state;
      if (!S_Enable) begin
         state_nxt = OFF;
      end else begin
         case (state)
            OFF:     state_nxt = WARMUP;
            WARMUP:  if (warm_cnt == WW'(WARMUP_CYC - 1))
                        state_nxt = (PIPE_LAT == 0) ? RUN : SKIP;
            SKIP:    if (cap_tick && (skip_cnt == SW'(PIPE_LAT - 1)))
                        state_nxt = RUN;
            default: state_nxt = state;
         endcase
      end
   end

   // The divider restarts from 0 on entry to SKIP, so S_ADC_Clk rises on the
   // very edge that ends WARMUP.
   always_comb begin
      div_nxt = '0;
      if (acq && acq_nxt)
         div_nxt = (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
   end

   // ---- FSM: outputs ----
   always_comb begin
      S_PWRDN   = (state == OFF);
      S_ADC_Clk = adc_clk_q;
   end

   // ---- FSM: state register and counters ----
   always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
      if (!sys_rst_pin) begin
         state     <= OFF;
         warm_cnt  <= '0;
         div_cnt   <= '0;
         skip_cnt  <= '0;
         adc_clk_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         warm_cnt  <= (state == WARMUP) ? warm_cnt + WW'(1) : '0;
         div_cnt   <= div_nxt;
         adc_clk_q <= acq_nxt && (div_nxt < DW'(CLK_DIV / 2));
         if (state != SKIP)
            skip_cnt <= '0;
         else if (cap_tick)
            skip_cnt <= skip_cnt + SW'(1);
      end
   end

   // ---- stage p1: captured word waiting for its FIFO push ----
   logic        push_vld_p1;
   logic [0:9]  cap_word_p1;
   logic        cap_otr_p1;

`ifdef PLB_ADC_AVG4_EN
   logic [11:0] avg_acc;
   logic [11:0] avg_sum;
   logic [1:0]  avg_cnt;
   logic        avg_otr;

   assign avg_sum = avg_acc + {2'b00, S_ADC_Data};

   always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
      if (!sys_rst_pin) begin
         push_vld_p1 <= 1'b0;
         avg_cnt     <= '0;
         avg_acc     <= '0;
         avg_otr     <= 1'b0;
      end else begin
         push_vld_p1 <= 1'b0;
         if (state != RUN) begin
            avg_cnt <= '0;
            avg_acc <= '0;
            avg_otr <= 1'b0;
         end else if (run_tick) begin
            if (avg_cnt == 2'd3) begin
               push_vld_p1 <= 1'b1;
               cap_word_p1 <= avg_sum[11:2];
               cap_otr_p1  <= avg_otr | S_ADC_OTR;
               avg_cnt     <= '0;
               avg_acc     <= '0;
               avg_otr     <= 1'b0;
            end else begin
               avg_cnt <= avg_cnt + 2'd1;
               avg_acc <= avg_sum;
               avg_otr <= avg_otr | S_ADC_OTR;
            end
         end
      end
   end
`else
   always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
      if (!sys_rst_pin)
         push_vld_p1 <= 1'b0;
      else
         push_vld_p1 <= run_tick;
   end

   always_ff @(posedge sys_clk_pin) begin
      if (cap_tick) begin
         cap_word_p1 <= S_ADC_Data;
         cap_otr_p1  <= S_ADC_OTR;
      end
   end
`endif

   // ---- stage p2: FIFO storage and read port ----
   logic [0:9] mem [16];
   logic [3:0] wr_ptr, rd_ptr;
   logic       pop, full, wr_en;

   assign pop        = Rd_Req && (Fifo_Count != 5'd0);
   assign full       = (Fifo_Count == 5'd16);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_en      = push_vld_p1 && (!full || pop);
   assign Fifo_Empty = (Fifo_Count == 5'd0);

   always_ff @(posedge sys_clk_pin) begin
      if (wr_en)
         mem[wr_ptr] <= cap_word_p1;
   end

   always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
      if (!sys_rst_pin) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         Fifo_Count <= '0;
         Rd_Data    <= '0;
         Rd_Valid   <= 1'b0;
         Overflow   <= 1'b0;
         Otr_Seen   <= 1'b0;
      end else begin
         Rd_Valid <= pop;
         if (wr_en)
            wr_ptr <= wr_ptr + 4'd1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 4'd1;
            Rd_Data <= mem[rd_ptr];
         end
         case ({wr_en, pop})
            2'b10:   Fifo_Count <= Fifo_Count + 5'd1;
            2'b01:   Fifo_Count <= Fifo_Count - 5'd1;
            default: Fifo_Count <= Fifo_Count;
         endcase
         Overflow <= (push_vld_p1 && full && !pop) || (Overflow && !Status_Clr);
         Otr_Seen <= (wr_en && cap_otr_p1) || (Otr_Seen && !Status_Clr);
      end
   end

endmodule

// File: tb/tb_plb_adc.sv
module tb_plb_adc;
   localparam int CLK_DIV    = 4;
   localparam int WARMUP_CYC = 64;
   localparam int PIPE_LAT   = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, otr, rd, clr;
   logic [0:9] data;
   logic       adc_clk, pwrdn, rd_valid, ovf, otr_seen, empty;
   logic [0:9] rd_data;
   logic [4:0] count;

   int errors = 0;
   int checks = 0;

   plb_adc #(.CLK_DIV(CLK_DIV), .WARMUP_CYC(WARMUP_CYC), .PIPE_LAT(PIPE_LAT)) dut (
      .sys_clk_pin(clk),    .sys_rst_pin(rst_n), .S_Enable(en),
      .S_ADC_Data(data),    .S_ADC_OTR(otr),     .S_ADC_Clk(adc_clk),
      .S_PWRDN(pwrdn),      .Rd_Req(rd),         .Rd_Data(rd_data),
      .Rd_Valid(rd_valid),  .Fifo_Count(count),  .Fifo_Empty(empty),
      .Overflow(ovf),       .Otr_Seen(otr_seen), .Status_Clr(clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   // Acquisition is described by elapsed time since the enabling edge:
   // the clock starts WARMUP_CYC edges after that edge, sample k (k >= 1)
   // is taken CLK_DIV*k edges later, samples k > PIPE_LAT are kept and
   // reach the FIFO one edge after capture. The FIFO is a plain queue.
   int         m_n, m_start, m_t, m_k, m_sum, m_avgn;
   bit         m_on, m_pend, m_po, m_otracc, m_pop, m_full, m_sov, m_sotr;
   logic [9:0] m_pw;
   logic [9:0] m_q[$];
   logic [9:0] m_rd;
   bit         m_rv, m_ov, m_otr, m_adc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0; m_start = 0; m_on = 0; m_pend = 0; m_po = 0; m_pw = '0;
         m_q.delete(); m_rd = '0; m_rv = 0; m_ov = 0; m_otr = 0; m_adc = 0;
         m_sum = 0; m_avgn = 0; m_otracc = 0;
      end else begin
         m_pop  = rd && (m_q.size() != 0);
         m_full = (m_q.size() == 16);
         m_rv   = m_pop;
         if (m_pop) m_rd = m_q.pop_front();
         m_sov = 0; m_sotr = 0;
         if (m_pend) begin
            if (!m_full || m_pop) begin
               m_q.push_back(m_pw);
               m_sotr = m_po;
            end else begin
               m_sov = 1;
            end
         end
         m_ov  = m_sov  || (m_ov  && !clr);
         m_otr = m_sotr || (m_otr && !clr);

         m_pend = 0;
         if (!en) begin
            m_on = 0;
         end else if (!m_on) begin
            m_on = 1; m_start = m_n; m_sum = 0; m_avgn = 0; m_otracc = 0;
         end else begin
            m_t = m_n - m_start;
            if (m_t >= WARMUP_CYC + CLK_DIV && (m_t - WARMUP_CYC) % CLK_DIV == 0) begin
               m_k = (m_t - WARMUP_CYC) / CLK_DIV;
               if (m_k > PIPE_LAT) begin
`ifdef PLB_ADC_AVG4_EN
                  m_sum = m_sum + int'(data); m_otracc = m_otracc | otr; m_avgn++;
                  if (m_avgn == 4) begin
                     m_pend = 1; m_pw = 10'(m_sum >> 2); m_po = m_otracc;
                     m_sum = 0; m_avgn = 0; m_otracc = 0;
                  end
`else
                  m_pend = 1; m_pw = data; m_po = otr;
`endif
               end
            end
         end
         if (m_on) begin
            m_t = m_n - m_start;
            m_adc = (m_t >= WARMUP_CYC) && (((m_t - WARMUP_CYC) % CLK_DIV) < CLK_DIV / 2);
         end else begin
            m_adc = 0;
         end
         m_n++;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [20:0] got, exp;
      got = {pwrdn, adc_clk, count, empty, rd_valid, rd_data, ovf, otr_seen};
      exp = {!m_on, m_adc, 5'(m_q.size()), m_q.size() == 0, m_rv, m_rd, m_ov, m_otr};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL cycle_outputs: got %h expected %h at %0t", got, exp, $time);
      end
   end

   function automatic logic [9:0] ramp(input int t, input int base);
      return (t - 1 >= WARMUP_CYC) ? 10'(base + (t - 1 - WARMUP_CYC) / CLK_DIV) : 10'(base);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int rdp;
      rst_n = 0; en = 0; rd = 0; clr = 0; otr = 0; data = '0;
      repeat (3) tick;
      chk("rst_pwrdn", pwrdn, 1);
      chk("rst_adc_clk", adc_clk, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_overflow", ovf, 0);
      chk("rst_otr_seen", otr_seen, 0);
      rst_n = 1;
      tick;

`ifndef PLB_ADC_AVG4_EN
      // Ramp acquisition, no reads: fill, then overflow.
      en = 1;
      tick;
      chk("pwrdn_fall", pwrdn, 0);
      for (int t = 1; t <= 153; t++) begin
         data = ramp(t, 0);
         tick;
         if (t == 63)  chk("adc_clk_before_rise", adc_clk, 0);
         if (t == 64)  chk("adc_clk_first_rise", adc_clk, 1);
         if (t == 88)  chk("count_at_capture6", count, 0);
         if (t == 89)  chk("count_after_push6", count, 1);
         if (t == 152) chk("no_overflow_yet", ovf, 0);
      end
      chk("full_count", count, 16);
      chk("overflow_set", ovf, 1);
      en = 0; clr = 1;
      tick;
      clr = 0;
      chk("overflow_cleared", ovf, 0);
      chk("off_pwrdn", pwrdn, 1);
      rd = 1;
      for (int i = 0; i < 16; i++) begin
         tick;
         chk("ramp_rd_data", rd_data, 32'(5 + i));
         chk("ramp_rd_valid", rd_valid, 1);
      end
      chk("drained_empty", empty, 1);
      tick;
      chk("empty_read_valid", rd_valid, 0);
      chk("empty_read_hold", rd_data, 32'h014);
      rd = 0;

      // Three words, one with OTR, then power down mid-RUN.
      en = 1;
      tick;
      for (int t = 1; t <= 97; t++) begin
         data = ramp(t, 'h100);
         otr  = (t == 92);
         tick;
         if (t == 92) chk("otr_before_push", otr_seen, 0);
         if (t == 93) chk("otr_after_push", otr_seen, 1);
      end
      otr = 0;
      chk("three_words", count, 3);
      en = 0;
      tick;
      chk("drop_pwrdn", pwrdn, 1);
      chk("drop_adc_clk", adc_clk, 0);
      chk("drop_count_kept", count, 3);
      rd = 1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("off_read", rd_data, 32'h105 + 32'(i));
      end
      rd = 0;
      en = 1;
      tick;
      for (int t = 1; t <= 64; t++) begin
         tick;
         if (t == 63) chk("rewarm_adc_low", adc_clk, 0);
         if (t == 64) chk("rewarm_adc_rise", adc_clk, 1);
      end
`else
      // Averaging: 0x3FF,0x3FF,0x001,0x001 -> one word 0x200.
      en = 1;
      tick;
      for (int t = 1; t <= 101; t++) begin
         int kk;
         kk = (t - 1 >= WARMUP_CYC) ? (t - 1 - WARMUP_CYC) / CLK_DIV + 1 : 0;
         data = (kk == 6 || kk == 7) ? 10'h3FF : (kk == 8 || kk == 9) ? 10'h001 : 10'h000;
         tick;
         if (t == 100) chk("avg_count_before", count, 0);
      end
      chk("avg_one_push", count, 1);
      rd = 1;
      tick;
      rd = 0;
      chk("avg_word", rd_data, 32'h200);
`endif

      // Randomized traffic against the model, with a mid-run reset.
      en = 1; rdp = 10;
      for (int c = 0; c < 4000; c++) begin
         if (c % 500 == 0) rdp = (c / 500 % 4 == 0) ? 0 : (c / 500 % 4 == 1) ? 10 :
                                 (c / 500 % 4 == 2) ? 30 : 60;
         if ($urandom_range(0, 399) == 0) en = ~en;
         rd   = ($urandom_range(0, 99) < rdp);
         data = 10'($urandom);
         otr  = ($urandom_range(0, 15) == 0);
         clr  = ($urandom_range(0, 63) == 0);
         if (c == 2100) rst_n = 0;
         if (c == 2102) rst_n = 1;
         tick;
      end
      rd = 0; clr = 0;
      tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
